// File: rtl/rv64_decode_stage.sv
// RV64I(+M when DECODE_RV64M_EN is defined) decode to ALU op code, registered output with a 2-entry skid buffer.
// One-cycle latency into an empty stage; in_ready is a registered !full, so nothing combinational runs from in_* to out_*.
module rv64_decode_stage #(
  parameter int              XLEN       = 64,
  parameter int              OP_W       = 8,
  parameter logic [OP_W-1:0] ILLEGAL_OP = OP_W'(8'hFF)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_op,
  output logic [4:0]      out_rs1_idx,
  output logic [4:0]      out_rs2_idx,
  output logic [4:0]      out_rd_idx,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_shamt,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  output logic            out_writes_rd
);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] pc;
    logic            illegal;
    logic            wrd;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, sh6, sh5;
  logic [OP_W-1:0] op;
  logic            legal, no_rd;
  logic [XLEN-1:0] imm, shamt;
  dec_t            dec;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-20){in_instr[31]}}, in_instr[31:12]};
  assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign sh6   = {{(XLEN-6){1'b0}}, in_instr[25:20]};
  assign sh5   = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  always_comb begin
    op    = '0;
    legal = 1'b1;
    no_rd = 1'b0;
    imm   = '0;
    shamt = '0;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: op = OP_W'(0);
            3'd1: op = OP_W'(5);
            3'd2: op = OP_W'(8);
            3'd3: op = OP_W'(9);
            3'd4: op = OP_W'(2);
            3'd5: op = OP_W'(6);
            3'd6: op = OP_W'(3);
            3'd7: op = OP_W'(4);
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'd0) op = OP_W'(1);
        else if (f7 == 7'b0100000 && f3 == 3'd5) op = OP_W'(7);
`ifdef DECODE_RV64M_EN
        else if (f7 == 7'b0000001) op = OP_W'(10) + OP_W'(f3);
`endif
        else legal = 1'b0;
      end
      7'b0111011: begin
        if (f7 == 7'b0000000 && f3 == 3'd0) op = OP_W'(33);
        else if (f7 == 7'b0000000 && f3 == 3'd1) op = OP_W'(35);
        else if (f7 == 7'b0000000 && f3 == 3'd5) op = OP_W'(36);
        else if (f7 == 7'b0100000 && f3 == 3'd0) op = OP_W'(34);
        else if (f7 == 7'b0100000 && f3 == 3'd5) op = OP_W'(37);
`ifdef DECODE_RV64M_EN
        else if (f7 == 7'b0000001 && f3 == 3'd0) op = OP_W'(38);
        else if (f7 == 7'b0000001 && f3 >= 3'd4) op = OP_W'(35) + OP_W'(f3);
`endif
        else legal = 1'b0;
      end
      7'b0010011: begin
        imm = imm_i;
        case (f3)
          3'd0: op = OP_W'(18);
          3'd2: op = OP_W'(25);
          3'd3: op = OP_W'(26);
          3'd4: op = OP_W'(19);
          3'd6: op = OP_W'(20);
          3'd7: op = OP_W'(21);
          3'd1: begin
            shamt = sh6;
            if (in_instr[31:26] == 6'b000000) op = OP_W'(22);
            else legal = 1'b0;
          end
          default: begin
            shamt = sh6;
            if (in_instr[31:26] == 6'b000000) op = OP_W'(23);
            else if (in_instr[31:26] == 6'b010000) op = OP_W'(24);
            else legal = 1'b0;
          end
        endcase
      end
      7'b0011011: begin
        imm   = imm_i;
        shamt = sh5;
        if (f3 == 3'd0) begin
          op    = OP_W'(29);
          shamt = '0;
        end else if (f3 == 3'd1 && f7 == 7'b0000000) op = OP_W'(30);
        else if (f3 == 3'd5 && f7 == 7'b0000000) op = OP_W'(31);
        else if (f3 == 3'd5 && f7 == 7'b0100000) op = OP_W'(32);
        else legal = 1'b0;
      end
      7'b0000011: begin
        imm = imm_i;
        case (f3)
          3'd0: op = OP_W'(59);
          3'd1: op = OP_W'(60);
          3'd2: op = OP_W'(61);
          3'd3: op = OP_W'(65);
          3'd4: op = OP_W'(62);
          3'd5: op = OP_W'(63);
          3'd6: op = OP_W'(64);
          default: legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        imm   = imm_s;
        no_rd = 1'b1;
        if (f3 <= 3'd3) op = OP_W'(43) + OP_W'(f3);
        else legal = 1'b0;
      end
      7'b1100011: begin
        imm   = imm_b;
        no_rd = 1'b1;
        case (f3)
          3'd0: op = OP_W'(47);
          3'd1: op = OP_W'(48);
          3'd4: op = OP_W'(49);
          3'd5: op = OP_W'(50);
          3'd6: op = OP_W'(51);
          3'd7: op = OP_W'(52);
          default: legal = 1'b0;
        endcase
      end
      7'b1101111: begin
        imm = imm_j;
        op  = OP_W'(53);
      end
      7'b1100111: begin
        imm = imm_i;
        if (f3 == 3'd0) op = OP_W'(54);
        else legal = 1'b0;
      end
      7'b0110111: begin
        imm = imm_u;
        op  = OP_W'(55);
      end
      7'b0010111: begin
        imm = imm_u;
        op  = OP_W'(56);
      end
      7'b1110011: begin
        imm   = imm_i;
        no_rd = 1'b1;
        if (in_instr == 32'h0000_0073) op = OP_W'(57);
        else if (in_instr == 32'h0010_0073) op = OP_W'(58);
        else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    // Illegal words still flow in order, but carry no immediate/shift payload.
    if (!legal) begin
      op    = ILLEGAL_OP;
      imm   = '0;
      shamt = '0;
    end
  end

  always_comb begin
    dec         = '0;
    dec.op      = op;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.imm     = imm;
    dec.shamt   = shamt;
    dec.pc      = in_pc;
    dec.illegal = !legal;
    dec.wrd     = legal && !no_rd && (in_instr[11:7] != 5'd0);
  end

  state_e state_q, state_d;
  dec_t   out_q, out_d, skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   acc;

  // in_ready_q always equals (state_q != TWO), so acc never fires in TWO.
  assign acc = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          out_d   = dec;
          state_d = ONE;
        end
        ONE: begin
          if (acc && out_ready) begin
            out_d = dec;
          end else if (acc) begin
            skid_d  = dec;
            state_d = TWO;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        TWO: if (out_ready) begin
          out_d   = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != EMPTY);
  assign out_op        = out_q.op;
  assign out_rs1_idx   = out_q.rs1;
  assign out_rs2_idx   = out_q.rs2;
  assign out_rd_idx    = out_q.rd;
  assign out_imm       = out_q.imm;
  assign out_shamt     = out_q.shamt;
  assign out_pc        = out_q.pc;
  assign out_illegal   = out_q.illegal;
  assign out_writes_rd = out_q.wrd;

endmodule

// File: tb/tb_rv64_decode_stage.sv
// Scoreboarded bench for rv64_decode_stage: directed decode vectors, backpressure, flush and mid-flight reset.
module tb_rv64_decode_stage;
  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_imm, out_shamt, out_pc;
  logic [7:0]  out_op;
  logic [4:0]  out_rs1_idx, out_rs2_idx, out_rd_idx;
  logic        out_illegal, out_writes_rd;

  always #5 clk = ~clk;

  rv64_decode_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rs1_idx(out_rs1_idx), .out_rs2_idx(out_rs2_idx), .out_rd_idx(out_rd_idx),
    .out_imm(out_imm), .out_shamt(out_shamt), .out_pc(out_pc),
    .out_illegal(out_illegal), .out_writes_rd(out_writes_rd)
  );

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm, shamt;
    logic        wrd;
  } vec_t;
  typedef struct {
    vec_t        v;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] pc_n = 64'h8000_0000;
  logic        toggle_en = 1'b0;
  logic [6:0]  rdy_pat = 7'b1101011;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] instr, input logic [7:0] op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] imm,
                               input logic [63:0] shamt, input logic wrd);
    vec_t v;
    v.instr = instr; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.imm = imm; v.shamt = shamt; v.wrd = wrd;
    return v;
  endfunction

  // Present one word; push its expectation at the negedge where the handshake is seen.
  task automatic send(input vec_t v);
    bit   got = 0;
    exp_t e;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = pc_n;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.v = v; e.pc = pc_n;
        sb.push_back(e);
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL send timeout: in_ready never seen for instr %h", v.instr);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pc_n     = pc_n + 64'd4;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk); #1;
      if (toggle_en) out_ready = rdy_pat[cyc % 7];
      cyc++;
    end
  end

  // Monitor: pops on every output transfer; also checks outputs hold while stalled.
  exp_t         e;
  logic         have_prev = 1'b0;
  logic [216:0] prev_snap, cur_snap;
  always @(negedge clk) begin
    cur_snap = {out_op, out_rs1_idx, out_rs2_idx, out_rd_idx, out_imm, out_shamt, out_pc,
                out_illegal, out_writes_rd};
    if (!reset_n || flush) begin
      sb.delete();
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        n_cmp++;
        if (!out_valid || cur_snap !== prev_snap) begin
          n_bad++;
          $display("FAIL stall stability: got valid=%b %h, expected held %h", out_valid, cur_snap, prev_snap);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected output: op %0d pc %h with empty scoreboard", out_op, out_pc);
        end else begin
          e = sb.pop_front();
          check($sformatf("op/idx/flags instr %h", e.v.instr),
                64'({out_op, out_rs1_idx, out_rs2_idx, out_rd_idx, out_illegal, out_writes_rd}),
                64'({e.v.op, e.v.rs1, e.v.rs2, e.v.rd, (e.v.op == 8'hFF), e.v.wrd}));
          check($sformatf("imm instr %h", e.v.instr), out_imm, e.v.imm);
          check($sformatf("shamt instr %h", e.v.instr), out_shamt, e.v.shamt);
          check($sformatf("pc instr %h", e.v.instr), out_pc, e.pc);
        end
      end
      have_prev = out_valid && !out_ready;
      prev_snap = cur_snap;
    end
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    vec_t v_sub, v_lui, v_ld, v_srai;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

    vecs.push_back(mkv(32'hFFF10093, 8'd18, 5'd2, 5'd31, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1));
    vecs.push_back(mkv(32'h43F35293, 8'd24, 5'd6, 5'd31, 5'd5, 64'h43F, 64'd63, 1'b1));
    vecs.push_back(mkv(32'h03F35293, 8'd23, 5'd6, 5'd31, 5'd5, 64'h03F, 64'd63, 1'b1));
`ifdef DECODE_RV64M_EN
    vecs.push_back(mkv(32'h022081B3, 8'd10, 5'd1, 5'd2, 5'd3, 64'd0, 64'd0, 1'b1));
    vecs.push_back(mkv(32'h023150BB, 8'd40, 5'd2, 5'd3, 5'd1, 64'd0, 64'd0, 1'b1));
`else
    vecs.push_back(mkv(32'h022081B3, 8'hFF, 5'd1, 5'd2, 5'd3, 64'd0, 64'd0, 1'b0));
    vecs.push_back(mkv(32'h023150BB, 8'hFF, 5'd2, 5'd3, 5'd1, 64'd0, 64'd0, 1'b0));
`endif
    vecs.push_back(mkv(32'h00208033, 8'd0,  5'd1, 5'd2, 5'd0, 64'd0, 64'd0, 1'b0));
    vecs.push_back(mkv(32'h402081B3, 8'd1,  5'd1, 5'd2, 5'd3, 64'd0, 64'd0, 1'b1));
    vecs.push_back(mkv(32'h0020B423, 8'd46, 5'd1, 5'd2, 5'd8, 64'd8, 64'd0, 1'b0));
    vecs.push_back(mkv(32'hFE208EE3, 8'd47, 5'd1, 5'd2, 5'd29, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0));
    vecs.push_back(mkv(32'h123452B7, 8'd55, 5'd8, 5'd3, 5'd5, 64'h12345, 64'd0, 1'b1));
    vecs.push_back(mkv(32'hFF9FF0EF, 8'd53, 5'd31, 5'd25, 5'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1));
    vecs.push_back(mkv(32'h00000073, 8'd57, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0));
    vecs.push_back(mkv(32'h0010809B, 8'd29, 5'd1, 5'd1, 5'd1, 64'd1, 64'd0, 1'b1));
    vecs.push_back(mkv(32'h0210909B, 8'hFF, 5'd1, 5'd1, 5'd1, 64'd0, 64'd0, 1'b0));
    vecs.push_back(mkv(32'h4051D11B, 8'd32, 5'd3, 5'd5, 5'd2, 64'h405, 64'd5, 1'b1));
    vecs.push_back(mkv(32'hFFFFFFFF, 8'hFF, 5'd31, 5'd31, 5'd31, 64'd0, 64'd0, 1'b0));
    vecs.push_back(mkv(32'h8010D093, 8'hFF, 5'd1, 5'd1, 5'd1, 64'd0, 64'd0, 1'b0));
    vecs.push_back(mkv(32'h01013283, 8'd65, 5'd2, 5'd16, 5'd5, 64'd16, 64'd0, 1'b1));
    v_srai = vecs[1];
    v_sub  = vecs[6];
    v_lui  = vecs[9];
    v_ld   = vecs[17];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_op", 64'(out_op), 64'd0);
    check("reset out_imm", out_imm, 64'd0);
    check("reset out_illegal/writes_rd", 64'({out_illegal, out_writes_rd}), 64'd0);
    reset_n = 1'b1;

    // First-word latency
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vecs[0]);
    @(negedge clk);
    check("latency out_valid", 64'(out_valid), 64'd1);
    check("latency out_op", 64'(out_op), 64'd18);
    @(posedge clk); #1;

    // All vectors with a stuttering consumer
    toggle_en = 1'b1;
    foreach (vecs[i]) send(vecs[i]);
    toggle_en = 1'b0;
    out_ready = 1'b1;
    drain("stream drain");

    // Three back-to-back words against a stalled consumer
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin send(v_sub); send(v_lui); send(v_ld); end
      begin
        repeat (3) @(negedge clk);
        check("full in_ready", 64'(in_ready), 64'd0);
        check("full out_valid", 64'(out_valid), 64'd1);
        check("full out_op head", 64'(out_op), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("backpressure drain");

    // Flush while full with a word offered in the same cycle
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(v_sub); send(v_lui);
    in_valid = 1'b1; in_instr = v_ld.instr; in_pc = pc_n;
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    repeat (5) @(negedge clk);
    check("flush no late output", 64'(out_valid), 64'd0);

    // Asynchronous reset while full
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(v_sub); send(v_lui);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset in_ready", 64'(in_ready), 64'd1);
    check("async reset out_op", 64'(out_op), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(v_srai);
    drain("post-reset drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
